// File: rtl/dart_pkg.sv
// Shared definitions for the dart game core and its downstream scoreboard.
package dart_pkg;

  localparam int ID_W        = 3;
  localparam int DEF_SCORE_W = 5;
  localparam int DEF_TOTAL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } dart_state_e;

endpackage

// File: rtl/dart_leader_tracker.sv
// Running leader / tie register. Evaluated on the new total of each thrower
// whose throw actually changed (or re-wrote) its total.
module dart_leader_tracker
  import dart_pkg::*;
#(
  parameter int TOTAL_W = DEF_TOTAL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               upd_i,
  input  logic [ID_W-1:0]    id_i,
  input  logic [TOTAL_W-1:0] total_i,
  output logic [ID_W-1:0]    leader_id_o,
  output logic [TOTAL_W-1:0] leader_total_o,
  output logic               tie_o
);

  logic [ID_W-1:0]    leader_id_q, leader_id_d;
  logic [TOTAL_W-1:0] leader_total_q, leader_total_d;
  logic               tie_q, tie_d;

  always_comb begin
    leader_id_d    = leader_id_q;
    leader_total_d = leader_total_q;
    tie_d          = tie_q;
    if (clear_i) begin
      leader_id_d    = '0;
      leader_total_d = '0;
      tie_d          = 1'b0;
    end else if (upd_i) begin
      if (total_i > leader_total_q) begin
        leader_id_d    = id_i;
        leader_total_d = total_i;
        tie_d          = 1'b0;
      end else if (id_i == leader_id_q) begin
        leader_total_d = total_i;
        tie_d          = 1'b0;
      end else if (total_i == leader_total_q) begin
        // First player to reach the value keeps the lead.
        tie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leader_id_q    <= '0;
      leader_total_q <= '0;
      tie_q          <= 1'b0;
    end else begin
      leader_id_q    <= leader_id_d;
      leader_total_q <= leader_total_d;
      tie_q          <= tie_d;
    end
  end

  assign leader_id_o    = leader_id_q;
  assign leader_total_o = leader_total_q;
  assign tie_o          = tie_q;

endmodule

// File: rtl/dart_scoreboard.sv
// Per-player score accumulation, round tracking and game-over detection.
// Define DART_SCOREBOARD_BUST_EN to discard throws that would exceed TARGET_SCORE.
module dart_scoreboard
  import dart_pkg::*;
#(
  parameter int NUM_PLAYERS  = 5,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int TOTAL_W      = DEF_TOTAL_W,
  parameter int NUM_ROUNDS   = 3,
  parameter int TARGET_SCORE = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               score_valid,
  input  logic [ID_W-1:0]    player_id,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [ID_W-1:0]    rd_sel,
  output logic [TOTAL_W-1:0] rd_total,
  output logic [ID_W-1:0]    leader_id,
  output logic [TOTAL_W-1:0] leader_total,
  output logic               tie,
  output logic [1:0]         round,
  output logic               game_over,
  output logic               id_err,
  output logic               bust
);

  function automatic logic [TOTAL_W-1:0] sat_total(input logic [TOTAL_W:0] s);
    return s[TOTAL_W] ? {TOTAL_W{1'b1}} : s[TOTAL_W-1:0];
  endfunction

  logic [TOTAL_W-1:0] totals_q [NUM_PLAYERS];
  dart_state_e        state_q, state_d;
  logic [1:0]         round_q, round_d;
  logic [TOTAL_W-1:0] rd_total_q, rd_total_d;
  logic               id_err_q, bust_q;

  logic               id_ok, accept, add_en, do_bust;
  logic               last_player, final_round;
  logic [TOTAL_W-1:0] sel_total, new_total;
  logic [TOTAL_W:0]   raw_sum;

  always_comb begin
    id_ok       = int'(player_id) < NUM_PLAYERS;
    accept      = score_valid && (state_q != DONE) && id_ok && !new_game;
    last_player = int'(player_id) == NUM_PLAYERS - 1;
    final_round = int'(round_q) == NUM_ROUNDS - 1;
    sel_total   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (int'(player_id) == i) sel_total = totals_q[i];
    end
    raw_sum   = {1'b0, sel_total} + (TOTAL_W + 1)'(score_in);
    new_total = sat_total(raw_sum);
`ifdef DART_SCOREBOARD_BUST_EN
    do_bust = accept && (int'(raw_sum) > TARGET_SCORE);
`else
    do_bust = 1'b0;
`endif
    add_en = accept && !do_bust;
  end

  // Game FSM: busted throws still count toward round progression.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (new_game) begin
      state_d = IDLE;
      round_d = '0;
    end else if (accept) begin
      if (last_player && final_round) begin
        state_d = DONE;
      end else begin
        state_d = PLAY;
        if (last_player) round_d = round_q + 2'd1;
      end
    end
  end

  always_comb begin
    rd_total_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (int'(rd_sel) == i) rd_total_d = totals_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      round_q    <= '0;
      rd_total_q <= '0;
      id_err_q   <= 1'b0;
      bust_q     <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) totals_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      rd_total_q <= new_game ? '0 : rd_total_d;
      bust_q     <= do_bust;
      if (new_game)                 id_err_q <= 1'b0;
      else if (score_valid && !id_ok) id_err_q <= 1'b1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (new_game)                             totals_q[i] <= '0;
        else if (add_en && int'(player_id) == i) totals_q[i] <= new_total;
      end
    end
  end

  dart_leader_tracker #(
    .TOTAL_W (TOTAL_W)
  ) u_leader (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (new_game),
    .upd_i          (add_en),
    .id_i           (player_id),
    .total_i        (new_total),
    .leader_id_o    (leader_id),
    .leader_total_o (leader_total),
    .tie_o          (tie)
  );

  assign rd_total  = rd_total_q;
  assign round     = round_q;
  assign game_over = (state_q == DONE);
  assign id_err    = id_err_q;
  assign bust      = bust_q;

endmodule

// File: tb/tb_dart_scoreboard.sv
// Directed self-checking bench for dart_scoreboard (bust checks follow DART_SCOREBOARD_BUST_EN).
module tb_dart_scoreboard;

  logic       clk = 1'b0;
  logic       reset, new_game, score_valid;
  logic [2:0] player_id, rd_sel;
  logic [4:0] score_in;
  logic [7:0] rd_total, leader_total;
  logic [2:0] leader_id;
  logic       tie, game_over, id_err, bust;
  logic [1:0] round;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] v;

  always #5 clk = ~clk;

  dart_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .score_valid  (score_valid),
    .player_id    (player_id),
    .score_in     (score_in),
    .rd_sel       (rd_sel),
    .rd_total     (rd_total),
    .leader_id    (leader_id),
    .leader_total (leader_total),
    .tie          (tie),
    .round        (round),
    .game_over    (game_over),
    .id_err       (id_err),
    .bust         (bust)
  );

  task automatic throw(input logic [2:0] id, input logic [4:0] s);
    @(negedge clk);
    player_id = id; score_in = s; score_valid = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
  endtask

  task automatic read_tot(input logic [2:0] sel, output logic [7:0] val);
    @(negedge clk);
    rd_sel = sel;
    @(posedge clk); #1;
    val = rd_total;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; new_game = 1'b0; score_valid = 1'b0;
    player_id = '0; score_in = '0; rd_sel = '0;
    #1;
    total_cnt++; if (rd_total !== 8'd0) $display("FAIL reset_rd_total got %0d want 0", rd_total); else pass_cnt++;
    total_cnt++; if (leader_id !== 3'd0) $display("FAIL reset_leader_id got %0d want 0", leader_id); else pass_cnt++;
    total_cnt++; if (leader_total !== 8'd0) $display("FAIL reset_leader_total got %0d want 0", leader_total); else pass_cnt++;
    total_cnt++; if ({tie, game_over, id_err, bust} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {tie, game_over, id_err, bust}); else pass_cnt++;
    total_cnt++; if (round !== 2'd0) $display("FAIL reset_round got %0d want 0", round); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_order();
    rd_sel = 3'd0;
    throw(3'd0, 5'd5);
    total_cnt++; if (rd_total !== 8'd0) $display("FAIL rd_pre_update got %0d want 0", rd_total); else pass_cnt++;
    throw(3'd1, 5'd7);
    total_cnt++; if (rd_total !== 8'd5) $display("FAIL rd_post_update got %0d want 5", rd_total); else pass_cnt++;
    total_cnt++; if (leader_id !== 3'd1 || tie !== 1'b0) $display("FAIL order_lead_p1 got id=%0d tie=%b want id=1 tie=0", leader_id, tie); else pass_cnt++;
    throw(3'd2, 5'd7);
    throw(3'd3, 5'd3);
    throw(3'd4, 5'd1);
    total_cnt++; if (leader_id !== 3'd1) $display("FAIL order_leader_id got %0d want 1", leader_id); else pass_cnt++;
    total_cnt++; if (leader_total !== 8'd7) $display("FAIL order_leader_total got %0d want 7", leader_total); else pass_cnt++;
    total_cnt++; if (tie !== 1'b1) $display("FAIL order_tie got %b want 1", tie); else pass_cnt++;
    total_cnt++; if (round !== 2'd1) $display("FAIL order_round got %0d want 1", round); else pass_cnt++;
    read_tot(3'd2, v);
    total_cnt++; if (v !== 8'd7) $display("FAIL order_rd_p2 got %0d want 7", v); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    pulse_new_game();
    total_cnt++; if (round !== 2'd0 || leader_total !== 8'd0) $display("FAIL ng_clear got round=%0d lt=%0d want 0/0", round, leader_total); else pass_cnt++;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 5; p++) begin
        throw(3'(p), 5'd10);
        if (r == 2 && p == 3) begin
          total_cnt++; if (game_over !== 1'b0) $display("FAIL game_over_early got %b want 0", game_over); else pass_cnt++;
        end
      end
    end
    total_cnt++; if (game_over !== 1'b1) $display("FAIL game_over got %b want 1", game_over); else pass_cnt++;
    total_cnt++; if (round !== 2'd2) $display("FAIL full_round got %0d want 2", round); else pass_cnt++;
    total_cnt++; if (leader_id !== 3'd0 || leader_total !== 8'd30 || tie !== 1'b1) $display("FAIL full_leader got id=%0d lt=%0d tie=%b want 0/30/1", leader_id, leader_total, tie); else pass_cnt++;
    throw(3'd0, 5'd10);
    total_cnt++; if (leader_total !== 8'd30) $display("FAIL done_leader_total got %0d want 30", leader_total); else pass_cnt++;
    for (int p = 0; p < 5; p++) begin
      read_tot(3'(p), v);
      total_cnt++; if (v !== 8'd30) $display("FAIL done_total_p%0d got %0d want 30", p, v); else pass_cnt++;
    end
  endtask

  task automatic test_id_err();
    pulse_new_game();
    total_cnt++; if (id_err !== 1'b0 || game_over !== 1'b0) $display("FAIL ng_after_done got err=%b go=%b want 0/0", id_err, game_over); else pass_cnt++;
    throw(3'd1, 5'd3);
    throw(3'd6, 5'd9);
    total_cnt++; if (id_err !== 1'b1) $display("FAIL id_err_set got %b want 1", id_err); else pass_cnt++;
    total_cnt++; if (leader_id !== 3'd1 || leader_total !== 8'd3) $display("FAIL id_err_leader got id=%0d lt=%0d want 1/3", leader_id, leader_total); else pass_cnt++;
    for (int p = 0; p < 5; p++) begin
      read_tot(3'(p), v);
      total_cnt++; if (v !== ((p == 1) ? 8'd3 : 8'd0)) $display("FAIL id_err_total_p%0d got %0d want %0d", p, v, (p == 1) ? 3 : 0); else pass_cnt++;
    end
    read_tot(3'd6, v);
    total_cnt++; if (v !== 8'd0) $display("FAIL rd_oob got %0d want 0", v); else pass_cnt++;
    throw(3'd2, 5'd1);
    total_cnt++; if (id_err !== 1'b1) $display("FAIL id_err_sticky got %b want 1", id_err); else pass_cnt++;
    pulse_new_game();
    total_cnt++; if (id_err !== 1'b0) $display("FAIL id_err_clear got %b want 0", id_err); else pass_cnt++;
  endtask

  task automatic test_saturate();
    pulse_new_game();
    for (int k = 0; k < 9; k++) throw(3'd0, 5'd31);
    read_tot(3'd0, v);
    total_cnt++; if (v !== 8'd255) $display("FAIL sat_total got %0d want 255", v); else pass_cnt++;
    total_cnt++; if (leader_total !== 8'd255) $display("FAIL sat_leader got %0d want 255", leader_total); else pass_cnt++;
  endtask

  task automatic test_bust();
    pulse_new_game();
    throw(3'd0, 5'd31);
    throw(3'd0, 5'd24);
    throw(3'd0, 5'd10);
`ifdef DART_SCOREBOARD_BUST_EN
    total_cnt++; if (bust !== 1'b1) $display("FAIL bust_pulse got %b want 1", bust); else pass_cnt++;
    total_cnt++; if (leader_total !== 8'd55) $display("FAIL bust_leader got %0d want 55", leader_total); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bust !== 1'b0) $display("FAIL bust_one_cycle got %b want 0", bust); else pass_cnt++;
    read_tot(3'd0, v);
    total_cnt++; if (v !== 8'd55) $display("FAIL bust_total got %0d want 55", v); else pass_cnt++;
`else
    total_cnt++; if (bust !== 1'b0) $display("FAIL nobust_flag got %b want 0", bust); else pass_cnt++;
    total_cnt++; if (leader_total !== 8'd65) $display("FAIL nobust_leader got %0d want 65", leader_total); else pass_cnt++;
    read_tot(3'd0, v);
    total_cnt++; if (v !== 8'd65) $display("FAIL nobust_total got %0d want 65", v); else pass_cnt++;
`endif
  endtask

  task automatic test_clear_collision();
    pulse_new_game();
    rd_sel = 3'd1;
    throw(3'd1, 5'd6);
    @(negedge clk);
    new_game = 1'b1; score_valid = 1'b1; player_id = 3'd4; score_in = 5'd9;
    @(posedge clk); #1;
    new_game = 1'b0; score_valid = 1'b0;
    total_cnt++; if (leader_total !== 8'd0 || leader_id !== 3'd0 || tie !== 1'b0) $display("FAIL coll_leader got id=%0d lt=%0d tie=%b want 0/0/0", leader_id, leader_total, tie); else pass_cnt++;
    total_cnt++; if (round !== 2'd0 || game_over !== 1'b0 || rd_total !== 8'd0) $display("FAIL coll_state got round=%0d go=%b rd=%0d want 0/0/0", round, game_over, rd_total); else pass_cnt++;
    read_tot(3'd4, v);
    total_cnt++; if (v !== 8'd0) $display("FAIL coll_dropped got %0d want 0", v); else pass_cnt++;

    throw(3'd0, 5'd5);
    throw(3'd6, 5'd2);
    @(negedge clk);
    score_valid = 1'b1; player_id = 3'd2; score_in = 5'd9;
    #2 reset = 1'b0;
    #1;
    total_cnt++; if ({leader_id, leader_total, tie, round, game_over, id_err, bust, rd_total} !== 30'd0) $display("FAIL async_reset got lt=%0d err=%b want all 0", leader_total, id_err); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (leader_total !== 8'd0 || round !== 2'd0) $display("FAIL reset_held got lt=%0d round=%0d want 0/0", leader_total, round); else pass_cnt++;
    @(negedge clk);
    score_valid = 1'b0; reset = 1'b1;
    read_tot(3'd0, v);
    total_cnt++; if (v !== 8'd0) $display("FAIL reset_total_p0 got %0d want 0", v); else pass_cnt++;
    read_tot(3'd2, v);
    total_cnt++; if (v !== 8'd0) $display("FAIL reset_total_p2 got %0d want 0", v); else pass_cnt++;
    throw(3'd4, 5'd1);
    total_cnt++; if (round !== 2'd1 || leader_id !== 3'd4 || game_over !== 1'b0) $display("FAIL restart got round=%0d id=%0d go=%b want 1/4/0", round, leader_id, game_over); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_order();
    test_back_to_back();
    test_id_err();
`ifndef DART_SCOREBOARD_BUST_EN
    test_saturate();
`endif
    test_bust();
    test_clear_collision();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dart_scoreboard.md
# dart_scoreboard

Downstream consumer of the digital dart game core. It accumulates per-player totals from each published throw (`player_id`, `score_display`) and tracks rounds. It maintains the running leader and tie status and declares game over after a fixed number of rounds. Its outputs drive the result display and the winner indicator.

## Interface
- `NUM_PLAYERS`, 5: number of players; valid ids are 0..NUM_PLAYERS-1
- `SCORE_W`, 5: width of a single throw score
- `TOTAL_W`, 8: width of each per-player total
- `NUM_ROUNDS`, 3: rounds per game
- `TARGET_SCORE`, 60: bust threshold (used only with the bust feature)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `new_game`  in  1  synchronous clear pulse
- `score_valid`  in  1  one-cycle strobe: a throw is published this cycle
- `player_id`  in  3  thrower of the published score
- `score_in`  in  SCORE_W  throw score (game core `score_display`)
- `rd_sel`  in  3  player whose total is read back
- `rd_total`  out  TOTAL_W  registered total of `rd_sel`
- `leader_id`  out  3  current leader
- `leader_total`  out  TOTAL_W  leader's total
- `tie`  out  1  another player equals the leader's total
- `round`  out  2  current round, 0-based
- `game_over`  out  1  all rounds complete
- `id_err`  out  1  sticky: an out-of-range `player_id` was strobed
- `bust`  out  1  one-cycle pulse: a throw was discarded by the bust rule

## Operation
- FSM states:
  - IDLE: reset state, all totals 0.
  - PLAY: throws are accepted.
  - DONE: `game_over`=1 and `score_valid` is ignored.
- Transitions:
  - IDLE→PLAY on the first valid strobe; that strobe is accepted.
  - PLAY→DONE on the accepted throw of player NUM_PLAYERS-1 when `round`=NUM_ROUNDS-1.
  - Any state→IDLE on `new_game`.
- A throw is accepted when all of these hold: `score_valid`=1, state ≠ DONE, `player_id` < NUM_PLAYERS, and `new_game`=0.
- On an accepted throw, `total[player_id]` becomes `total[player_id]` + `score_in`, zero-extended and saturating at 2^TOTAL_W-1.
- Round tracking: an accepted throw from player NUM_PLAYERS-1 increments `round`, except when it enters DONE, where `round` holds at NUM_ROUNDS-1. Throw order is otherwise not checked.
- Out-of-range id with `score_valid`=1: the throw is dropped and `id_err` is set; `id_err` clears only on reset or `new_game`.
- Leader update, evaluated on the new total T of the thrower:
  - T > `leader_total`: the thrower becomes leader, `tie`=0.
  - Thrower is already leader: `leader_total`=T, `tie`=0.
  - Thrower is not leader and T = `leader_total`: `tie`=1; the leader is unchanged, so the first player to reach the value stays leader.
- `new_game` and `score_valid` in the same cycle: `new_game` wins and the throw is dropped.

## Timing
- Reset values: every output is 0, all totals are 0, state is IDLE.
- `leader_id`, `leader_total`, `tie`, `round`, `game_over` and `bust` update at the same edge that accepts the throw (0-cycle register latency).
- `rd_total` is the registered value of `total[rd_sel]` sampled at the edge, i.e. the pre-update value. A throw accepted at edge N is visible on `rd_total` after edge N+1.
- An `rd_sel` ≥ NUM_PLAYERS reads 0.
- Back-to-back `score_valid` every cycle is supported.
- Reset asserted mid-game clears everything immediately, without waiting for a clock.

## Configuration
- `DART_SCOREBOARD_BUST_EN` defined: a throw whose result would exceed TARGET_SCORE is discarded. The total is unchanged, `bust` pulses for one cycle, the leader is not re-evaluated, and the round still advances.
- Not defined: the saturating add is used and `bust` is tied to 0.

## Structure
- Shared package `dart_pkg` holds:
  - the FSM state enum (IDLE, PLAY, DONE)
  - the player id width constant (3)
  - the default score and total widths, shared with the game core
- One sub-module, `dart_leader_tracker`, contains the leader and tie register logic.
- Totals array, FSM and read port live in the top module.

## Test plan
- Reset, then the players' throws arrive in order 0..4 with scores 5,7,7,3,1. Required response:
  - leader_id=1, leader_total=7, tie=1, round=1
  - rd_sel=2 gives rd_total=7 one cycle later.
- 3 full rounds of score 10 from every player. Required response:
  - game_over=1 after the 15th strobe, round=2
  - a 16th strobe leaves all totals at 30.
- player_id=6 with score 9 → all totals unchanged and id_err=1; id_err stays 1 until new_game.
- Player 0 throws 31 ×9 with TOTAL_W=8 → total saturates at 255 (macro off).
- With `DART_SCOREBOARD_BUST_EN`: player 0 at 55 throws 10 → total stays 55, bust pulses one cycle; the same throw with the macro off → total 65.
- `new_game` and `score_valid` in the same cycle; reset pulsed low mid-round → the throw is dropped, state is IDLE, all outputs are 0.
